// File: rtl/apb_master_engine_if.sv
// ----------------------------------------------------------------------------
// apb_master_engine_if
//   APB bus bundle between the burst engine (master) and an APB fabric or
//   slave model. Signal names keep the engine's point of view: *_o are driven
//   by the master, *_i are driven by the slave side.
//
//   paddr_o   : APB address
//   psel_o    : two slave selects, [0] = 0x0001_F000..0x0001_FFFF,
//               [1] = 0x0002_F000..0x0002_FFFF
//   penable_o : APB enable (ACCESS phase)
//   pwrite_o  : 1 = write, 0 = read
//   pwdata_o  : write data
//   prdata_i  : read data
//   pready_i  : slave ready, ends the ACCESS phase
//   pslverr_i : slave error, qualified by pready_i
//
//   Handshake: a transfer is a one-cycle SETUP phase (psel != 0, penable = 0)
//   followed by ACCESS cycles (penable = 1) with address, select, direction
//   and write data held stable; the transfer ends on the first ACCESS cycle
//   in which pready_i is 1, and prdata_i / pslverr_i are sampled only then.
// ----------------------------------------------------------------------------
interface apb_master_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [1:0]            psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pready_i;
  logic                  pslverr_i;

  modport master (
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport slave (
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface

// File: rtl/apb_master_engine.sv
// ----------------------------------------------------------------------------
// apb_master_engine
//   Runs read or write bursts of 1..16 beats on an APB bus. Each beat is one
//   APB transfer at an address 4 bytes above the previous one; every beat is
//   decoded on its own into one of two slave windows. Write data comes from a
//   small FIFO that may be filled at any time, including before the burst.
//
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   wr_trans_i      : one-cycle write burst start (ignored when busy)
//   rd_trans_i      : one-cycle read burst start (wins over wr_trans_i)
//   trans_addr_i    : burst start address
//   burst_len_i     : number of beats minus one
//   wdata_i         : write data, pushed with wdata_push_i
//   wdata_push_i    : push request; dropped while the FIFO is full
//   wdata_full_o    : FIFO full
//   read_data_o     : data of the last completed read beat
//   trans_done_o    : one-cycle pulse per completed beat
//   trans_error_o   : beat error, valid with trans_done_o
//   busy_o          : burst in progress
//   dbg_state_o     : current FSM state (IDLE=0, WAIT_WDATA=1, SETUP=2,
//                     ACCESS=3)
//   apb             : APB master port
//
//   All outputs are registers. A beat whose address hits no window never
//   reaches the bus and completes with an error; a beat whose slave never
//   raises pready_i is aborted with an error after 16 ACCESS cycles. Errors
//   do not end the burst.
// ----------------------------------------------------------------------------
module apb_master_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_trans_i,
  input  logic                  rd_trans_i,
  input  logic [ADDR_WIDTH-1:0] trans_addr_i,
  input  logic [3:0]            burst_len_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wdata_push_i,
  output logic                  wdata_full_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  trans_done_o,
  output logic                  trans_error_o,
  output logic                  busy_o,
  output logic [1:0]            dbg_state_o,
  apb_master_engine_if.master   apb
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_WDATA = 2'd1;
  localparam logic [1:0] S_SETUP      = 2'd2;
  localparam logic [1:0] S_ACCESS     = 2'd3;

  // FIFO_DEPTH is a power of two >= 2, so the pointers wrap on their own.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Window decode: a window is one 4 KiB page.
  function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] page;
    page   = a >> 12;
    decode = 2'b00;
    if (page == ADDR_WIDTH'(32'h1F))      decode = 2'b01;
    else if (page == ADDR_WIDTH'(32'h2F)) decode = 2'b10;
  endfunction

  // FSM and burst context
  logic [1:0]            state_q, state_d;
  logic                  live_q, live_d;   // SETUP outputs already on the bus
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            beat_q, beat_d;
  logic                  dir_q, dir_d;     // 1 = write
  logic [4:0]            wd_q, wd_d;

  // Registered outputs
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [1:0]            psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  full_q, full_d;

  // Write-data FIFO
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok, pop;

  // Combinational helpers
  logic                  load_setup, finish;
  logic [ADDR_WIDTH-1:0] setup_addr;
  logic                  setup_dir;

  always_comb begin
    state_d    = state_q;
    live_d     = live_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    dir_d      = dir_q;
    wd_d       = wd_q;
    paddr_d    = paddr_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    pop        = 1'b0;
    load_setup = 1'b0;
    finish     = 1'b0;
    setup_addr = addr_q;
    setup_dir  = dir_q;

    case (state_q)
      S_IDLE: begin
        setup_addr = trans_addr_i;
        if (rd_trans_i) begin
          addr_d     = trans_addr_i;
          len_d      = burst_len_i;
          beat_d     = 4'd0;
          dir_d      = 1'b0;
          setup_dir  = 1'b0;
          state_d    = S_SETUP;
          load_setup = 1'b1;
        end else if (wr_trans_i) begin
          addr_d    = trans_addr_i;
          len_d     = burst_len_i;
          beat_d    = 4'd0;
          dir_d     = 1'b1;
          setup_dir = 1'b1;
          if (count_q != '0) begin
            state_d    = S_SETUP;
            load_setup = 1'b1;
          end else begin
            state_d = S_WAIT_WDATA;
          end
        end
      end

      S_WAIT_WDATA: begin
        if (count_q != '0) begin
          state_d    = S_SETUP;
          load_setup = 1'b1;
        end
      end

      S_SETUP: begin
        if (!live_q) begin
          // Entered from a completed beat: the done cycle showed an idle
          // bus, so the SETUP phase of this beat goes out now.
          load_setup = 1'b1;
        end else if (psel_q != 2'b00) begin
          state_d   = S_ACCESS;
          penable_d = 1'b1;
          wd_d      = 5'd0;
        end else begin
          // No window hit: the beat never touches the bus.
          finish  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end

      S_ACCESS: begin
        if (apb.pready_i) begin
          finish = 1'b1;
          err_d  = apb.pslverr_i;
          if (!dir_q) rdata_d = apb.prdata_i;
        end else if (wd_q == 5'd15) begin
          finish  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          wd_d = wd_q + 5'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      done_d    = 1'b1;
      psel_d    = 2'b00;
      penable_d = 1'b0;
      pop       = dir_q;
      if (beat_q == len_q) begin
        state_d = S_IDLE;
      end else begin
        addr_d  = addr_q + ADDR_WIDTH'(4);
        beat_d  = beat_q + 4'd1;
        state_d = S_SETUP;
        live_d  = 1'b0;
      end
    end

    push_ok = wdata_push_i && !full_q;
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);

    // Next write beat with no data left after this pop waits for a push.
    if (finish && (beat_q != len_q) && dir_q && (count_d == '0)) begin
      state_d = S_WAIT_WDATA;
    end

    if (load_setup) begin
      live_d    = 1'b1;
      paddr_d   = setup_addr;
      psel_d    = decode(setup_addr);
      penable_d = 1'b0;
      pwrite_d  = setup_dir;
      pwdata_d  = setup_dir ? mem_q[rd_ptr_q] : '0;
    end

    busy_d = (state_d != S_IDLE);
    full_d = (count_d == CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      live_q    <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      dir_q     <= 1'b0;
      wd_q      <= '0;
      paddr_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      full_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      live_q    <= live_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      dir_q     <= dir_d;
      wd_q      <= wd_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      full_q    <= full_d;
      count_q   <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign wdata_full_o  = full_q;
  assign read_data_o   = rdata_q;
  assign trans_done_o  = done_q;
  assign trans_error_o = err_q;
  assign busy_o        = busy_q;
  assign dbg_state_o   = state_q;

  assign apb.paddr_o   = paddr_q;
  assign apb.psel_o    = psel_q;
  assign apb.penable_o = penable_q;
  assign apb.pwrite_o  = pwrite_q;
  assign apb.pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_master_engine.sv
module tb_apb_master_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        wr_trans_i, rd_trans_i;
  logic [31:0] trans_addr_i;
  logic [3:0]  burst_len_i;
  logic [31:0] wdata_i;
  logic        wdata_push_i;
  logic        wdata_full_o;
  logic [31:0] read_data_o;
  logic        trans_done_o, trans_error_o, busy_o;
  logic [1:0]  dbg_state_o;

  apb_master_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb_if ();

  apb_master_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_trans_i   (wr_trans_i),
    .rd_trans_i   (rd_trans_i),
    .trans_addr_i (trans_addr_i),
    .burst_len_i  (burst_len_i),
    .wdata_i      (wdata_i),
    .wdata_push_i (wdata_push_i),
    .wdata_full_o (wdata_full_o),
    .read_data_o  (read_data_o),
    .trans_done_o (trans_done_o),
    .trans_error_o(trans_error_o),
    .busy_o       (busy_o),
    .dbg_state_o  (dbg_state_o),
    .apb          (apb_if)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] done_exp_q[$];   // {error, read_data}
  logic [66:0] apb_exp_q[$];    // {paddr, psel, pwrite, pwdata}
  int pen_run = 0;
  int last_pen_run = 0;
  logic [31:0] model_rdata = '0;

  // slave model controls
  int          slave_wait = 0;
  logic        slave_hang = 1'b0;
  logic        slave_err = 1'b0;
  logic [31:0] slave_rdata = '0;
  int          acc_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    wdata_i = d;
    wdata_push_i = 1'b1;
    cycle();
    wdata_push_i = 1'b0;
  endtask

  task automatic start(input logic rd, input logic wr, input logic [31:0] a, input logic [3:0] len);
    rd_trans_i = rd;
    wr_trans_i = wr;
    trans_addr_i = a;
    burst_len_i = len;
    cycle();
    rd_trans_i = 1'b0;
    wr_trans_i = 1'b0;
  endtask

  task automatic exp_apb(input logic [31:0] a, input logic [1:0] sel, input logic wr, input logic [31:0] d);
    apb_exp_q.push_back({a, sel, wr, d});
  endtask

  task automatic exp_done(input logic err, input logic [31:0] d);
    done_exp_q.push_back({err, d});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 300) begin
      cycle();
      n++;
    end
    check(name, busy_o, 1'b0);
    cycle();
    cycle();
  endtask

  // ---------------- APB slave model ----------------
  initial begin
    apb_if.pready_i = 1'b0;
    apb_if.prdata_i = '0;
    apb_if.pslverr_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && apb_if.psel_o != 2'b00 && apb_if.penable_o) begin
        apb_if.pready_i = !slave_hang && (acc_cnt >= slave_wait);
        apb_if.prdata_i = slave_rdata;
        apb_if.pslverr_i = slave_err;
        acc_cnt++;
      end else begin
        apb_if.pready_i = 1'b0;
        apb_if.prdata_i = '0;
        apb_if.pslverr_i = 1'b0;
        acc_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [66:0] apb_got, apb_exp;
  logic [32:0] done_got, done_exp;
  always @(negedge clk) begin
    if (rst) begin
      pen_run = 0;
    end else begin
      if (apb_if.penable_o) pen_run++;
      if (apb_if.psel_o != 2'b00 && !apb_if.penable_o) begin
        apb_got = {apb_if.paddr_o, apb_if.psel_o, apb_if.pwrite_o,
                   apb_if.pwrite_o ? apb_if.pwdata_o : 32'h0};
        if (apb_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL apb_unexpected: got %0h expected none", apb_got);
        end else begin
          apb_exp = apb_exp_q.pop_front();
          check("apb_setup", apb_got, apb_exp);
        end
      end
      if (trans_done_o) begin
        last_pen_run = pen_run;
        pen_run = 0;
        done_got = {trans_error_o, read_data_o};
        if (done_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got %0h expected none", done_got);
        end else begin
          done_exp = done_exp_q.pop_front();
          check("beat_done", done_got, done_exp);
        end
      end
    end
  end

  // ---------------- global time limit ----------------
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    wr_trans_i = 1'b0;
    rd_trans_i = 1'b0;
    trans_addr_i = '0;
    burst_len_i = '0;
    wdata_i = '0;
    wdata_push_i = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // reset state
    check("rst_busy", busy_o, 1'b0);
    check("rst_full", wdata_full_o, 1'b0);
    check("rst_done", trans_done_o, 1'b0);
    check("rst_psel", apb_if.psel_o, 2'b00);
    check("rst_penable", apb_if.penable_o, 1'b0);
    check("rst_rdata", read_data_o, 32'h0);
    check("rst_state", dbg_state_o, 2'd0);

    // single read beat in window 0
    slave_wait = 0;
    slave_rdata = 32'hDEADBEEF;
    exp_apb(32'h0001_F000, 2'b01, 1'b0, 32'h0);
    exp_done(1'b0, 32'hDEADBEEF);
    start(1'b1, 1'b0, 32'h0001_F000, 4'd0);
    wait_idle("read1_idle");
    check("read1_pen_cycles", last_pen_run, 1);

    // read crossing out of window 0: second beat decodes to nothing
    slave_rdata = 32'h1234_5678;
    exp_apb(32'h0001_FFFC, 2'b01, 1'b0, 32'h0);
    exp_done(1'b0, 32'h1234_5678);
    exp_done(1'b1, 32'h0);
    start(1'b1, 1'b0, 32'h0001_FFFC, 4'd1);
    wait_idle("cross_idle");

    // fill FIFO, fifth push dropped, 4-beat write with wait states
    push_word(32'h11);
    push_word(32'h22);
    push_word(32'h33);
    check("full_after3", wdata_full_o, 1'b0);
    push_word(32'h44);
    check("full_after4", wdata_full_o, 1'b1);
    push_word(32'h55);
    check("full_after5", wdata_full_o, 1'b1);
    slave_wait = 1;
    exp_apb(32'h0002_F000, 2'b10, 1'b1, 32'h11);
    exp_apb(32'h0002_F004, 2'b10, 1'b1, 32'h22);
    exp_apb(32'h0002_F008, 2'b10, 1'b1, 32'h33);
    exp_apb(32'h0002_F00C, 2'b10, 1'b1, 32'h44);
    for (int i = 0; i < 4; i++) exp_done(1'b0, 32'h0);
    start(1'b0, 1'b1, 32'h0002_F000, 4'd3);
    repeat (3) cycle();
    start(1'b1, 1'b0, 32'h0001_F000, 4'd0);   // must be ignored while busy
    wait_idle("wburst_idle");
    check("wburst_full_clear", wdata_full_o, 1'b0);
    check("wburst_state", dbg_state_o, 2'd0);

    // write with empty FIFO stalls in WAIT_WDATA between beats
    slave_wait = 0;
    start(1'b0, 1'b1, 32'h0002_F200, 4'd1);
    repeat (3) cycle();
    check("stall0_state", dbg_state_o, 2'd1);
    check("stall0_psel", apb_if.psel_o, 2'b00);
    check("stall0_busy", busy_o, 1'b1);
    exp_apb(32'h0002_F200, 2'b10, 1'b1, 32'hA5);
    exp_done(1'b0, 32'h0);
    push_word(32'hA5);
    repeat (12) cycle();
    check("stall1_state", dbg_state_o, 2'd1);
    check("stall1_pending", done_exp_q.size(), 0);
    exp_apb(32'h0002_F204, 2'b10, 1'b1, 32'h5A);
    exp_done(1'b0, 32'h0);
    push_word(32'h5A);
    wait_idle("stall_idle");

    // simultaneous read and write start: read only, FIFO word kept
    push_word(32'h77);
    slave_rdata = 32'h0BAD_F00D;
    exp_apb(32'h0001_F020, 2'b01, 1'b0, 32'h0);
    exp_done(1'b0, 32'h0BAD_F00D);
    start(1'b1, 1'b1, 32'h0001_F020, 4'd0);
    wait_idle("both_idle");
    exp_apb(32'h0002_F010, 2'b10, 1'b1, 32'h77);
    exp_done(1'b0, 32'h0BAD_F00D);
    start(1'b0, 1'b1, 32'h0002_F010, 4'd0);
    repeat (2) cycle();
    check("kept_word_state", dbg_state_o != 2'd1, 1'b1);
    wait_idle("kept_idle");

    // slave error does not end the burst
    slave_err = 1'b1;
    slave_rdata = 32'hCAFE_F00D;
    exp_apb(32'h0001_F100, 2'b01, 1'b0, 32'h0);
    exp_apb(32'h0001_F104, 2'b01, 1'b0, 32'h0);
    exp_done(1'b1, 32'hCAFE_F00D);
    exp_done(1'b1, 32'hCAFE_F00D);
    start(1'b1, 1'b0, 32'h0001_F100, 4'd1);
    wait_idle("slverr_idle");
    slave_err = 1'b0;

    // watchdog abort after 16 ACCESS cycles
    slave_hang = 1'b1;
    exp_apb(32'h0002_F300, 2'b10, 1'b0, 32'h0);
    exp_done(1'b1, 32'h0);
    start(1'b1, 1'b0, 32'h0002_F300, 4'd0);
    wait_idle("wdog_idle");
    check("wdog_pen_cycles", last_pen_run, 16);

    // reset in the middle of an ACCESS phase
    exp_apb(32'h0001_F040, 2'b01, 1'b0, 32'h0);
    start(1'b1, 1'b0, 32'h0001_F040, 4'd0);
    begin
      int n = 0;
      while (!apb_if.penable_o && n < 10) begin
        cycle();
        n++;
      end
    end
    check("mid_rst_in_access", apb_if.penable_o, 1'b1);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    check("mid_rst_psel", apb_if.psel_o, 2'b00);
    check("mid_rst_penable", apb_if.penable_o, 1'b0);
    check("mid_rst_paddr", apb_if.paddr_o, 32'h0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_done", trans_done_o, 1'b0);
    check("mid_rst_state", dbg_state_o, 2'd0);
    rst = 1'b0;
    slave_hang = 1'b0;
    repeat (20) cycle();
    check("post_rst_busy", busy_o, 1'b0);

    // leftovers mean missing APB transfers or missing done pulses
    check("apb_q_drained", apb_exp_q.size(), 0);
    check("done_q_drained", done_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_engine.md
APB_MASTER_ENGINE -- requirements
Module: apb_master_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning write-data FIFO entries (power of 2).
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_trans_i  in  1  single-cycle write-burst start.
- rd_trans_i  in  1  single-cycle read-burst start.
- trans_addr_i  in  ADDR_WIDTH  burst start address.
- burst_len_i  in  4  beats minus 1.
- wdata_i  in  DATA_WIDTH  write data.
- wdata_push_i  in  1  push wdata_i into FIFO.
- wdata_full_o  out  1  FIFO full.
- read_data_o  out  DATA_WIDTH  read beat data.
- trans_done_o  out  1  one-cycle pulse per completed beat.
- trans_error_o  out  1  error flag, valid with trans_done_o.
- busy_o  out  1  burst in progress.
- paddr_o  out  ADDR_WIDTH  APB address.
- psel_o  out  2  APB selects; [0] = 0x0001_F000-0x0001_FFFF, [1] = 0x0002_F000-0x0002_FFFF.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  DATA_WIDTH  APB write data.
- prdata_i  in  DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT_WDATA, SETUP, ACCESS; all outputs registered.
REQ-006 IDLE: on rd_trans_i, SHALL latch addr/len, dir=read, beat_cnt=0, go SETUP; rd_trans_i wins over simultaneous wr_trans_i (wr dropped).
REQ-007 IDLE: on wr_trans_i alone, SHALL latch, dir=write; go SETUP if FIFO non-empty, else WAIT_WDATA.
REQ-008 wr_trans_i/rd_trans_i outside IDLE SHALL be ignored; busy_o=1 in every state except IDLE.
REQ-009 WAIT_WDATA SHALL go SETUP the cycle after FIFO becomes non-empty.
REQ-010 SETUP: paddr_o=current addr, psel_o=decode, penable_o=0, pwrite_o=dir, pwdata_o=FIFO head (write).
REQ-011 SETUP with no window hit SHALL drive psel_o=0, skip ACCESS, complete beat next cycle with trans_error_o=1, read_data_o=0, pop FIFO on write.
REQ-012 ACCESS: penable_o=1, psel/paddr/pwrite/pwdata held stable until pready_i=1.
REQ-013 Beat completes on ACCESS cycle with pready_i=1: next cycle trans_done_o=1, trans_error_o=pslverr_i, read_data_o=prdata_i (read) else unchanged, penable_o=0, psel_o=0; write pops FIFO.
REQ-014 Watchdog: 5-bit counter cleared entering ACCESS; after 16 ACCESS cycles without pready_i SHALL abort beat as error (trans_done_o=1, trans_error_o=1, read_data_o=0, write pops).
REQ-015 After beat: beat_cnt==len -> IDLE; else addr+=4 (mod 2^ADDR_WIDTH), beat_cnt+=1, SETUP (write with empty FIFO -> WAIT_WDATA); each beat decoded independently.
REQ-016 Error beats SHALL NOT terminate burst; remaining beats proceed.
REQ-017 FIFO: push when wdata_push_i and not full; push while full dropped even with same-cycle pop; push+pop when not full both apply; wdata_full_o registered from count.
REQ-018 FIFO push accepted in any state, including IDLE before wr_trans_i.

Reset
REQ-019 rst SHALL force IDLE, FIFO empty, beat_cnt=0, watchdog=0, every output 0 (wdata_full_o=0, busy_o=0).
REQ-020 rst mid-burst SHALL abandon burst at next edge; no further trans_done_o; psel_o/penable_o 0 next cycle.

Verification
REQ-021 Read, addr 0x0001_F000, len 0, pready_i=1 on first ACCESS, prdata_i=0xDEADBEEF -> psel_o=01 SETUP then ACCESS, trans_done_o once, read_data_o=0xDEADBEEF, error 0.
REQ-022 Push 4 words 0x11..0x44, wr_trans_i addr 0x0002_F000 len 3 -> 4 APB writes to 0x0002_F000/F004/F008/F00C, psel_o=10, pwdata 0x11..0x44, 4 done pulses, FIFO empty.
REQ-023 Write len 1, FIFO empty -> WAIT_WDATA, no psel; push 0xA5 -> beat 0 completes; stall until second push.
REQ-024 Read addr 0x0001_FFFC len 1 -> beat 0 psel_o=01; beat 1 addr 0x0002_0000 psel_o=00, done with error=1, read_data_o=0.
REQ-025 pready_i held 0 -> abort after 16 ACCESS cycles, trans_done_o=1, trans_error_o=1; pslverr_i=1 with pready_i -> error=1, burst continues.
REQ-026 rd_trans_i and wr_trans_i same cycle -> read only; 5th push with FIFO full dropped; rst mid-ACCESS -> all outputs 0 next cycle.
